// File: rtl/fifo_rd_serializer_pkg.sv
// Shared state encodings and default widths for the FIFO read-side serializer.
// W and S defaults are reused by the FIFO instance so both sides agree.
package fifo_rd_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } ser_state_e;

  localparam int DEF_W = 32;
  localparam int DEF_S = 8;

endpackage

// File: rtl/fifo_rd_serializer.sv
// Pops W-bit words from a registered-read FIFO and streams them out as
// W/S narrow beats on a valid/ready interface, flagging the last beat.
module fifo_rd_serializer
  import fifo_rd_serializer_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int S         = DEF_S,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic         in_empty,
  input  logic [W-1:0] in_data,
  output logic         o_r_en,
  output logic [S-1:0] o_sdata,
  output logic         o_svalid,
  input  logic         in_sready,
  output logic         o_slast,
  output logic [15:0]  o_words
);

  localparam int N  = W / S;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST = BW'(N - 1);

  ser_state_e    state_q;
  logic [W-1:0]  sh_q;
  logic [W-1:0]  sh_d;
  logic [BW-1:0] beat_q;
  logic [15:0]   words_q;
  logic          last;

  assign last = (beat_q == LAST);

  // Next slice moves toward whichever end is emitted first
  assign sh_d = LSB_FIRST ? (sh_q >> S) : (sh_q << S);

  assign o_sdata  = LSB_FIRST ? sh_q[S-1:0] : sh_q[W-1 -: S];
  assign o_svalid = (state_q == ST_SHIFT);
  assign o_slast  = (state_q == ST_SHIFT) & last;
  assign o_words  = words_q;

  always_comb begin
    o_r_en = 1'b0;
    unique case (state_q)
      ST_IDLE:  o_r_en = ~in_empty;
      ST_SHIFT: o_r_en = in_sready & last & ~in_empty;
      default:  o_r_en = 1'b0;
    endcase
    if (!in_rst_n) o_r_en = 1'b0;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      beat_q  <= '0;
      words_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!in_empty) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          sh_q    <= in_data;
          beat_q  <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (in_sready) begin
            if (last) begin
              words_q <= words_q + 16'd1;
              state_q <= in_empty ? ST_IDLE : ST_WAIT;
            end else begin
              sh_q   <= sh_d;
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench: behavioural FIFO with registered read data feeding
// an LSB-first and an MSB-first serializer in lockstep.
module tb_fifo_rd_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_empty;
  logic [31:0] in_data;
  logic        in_sready;
  logic        r_en_l, r_en_m;
  logic [7:0]  sdata_l, sdata_m;
  logic        svalid_l, svalid_m;
  logic        slast_l, slast_m;
  logic [15:0] words_l, words_m;

  logic [31:0] fq[$];
  int nvec;
  int nerr;

  fifo_rd_serializer #(.W(32), .S(8), .LSB_FIRST(1'b1)) dut_l (
    .in_clk(clk), .in_rst_n(rst_n), .in_empty(in_empty),
    .in_data(in_data), .o_r_en(r_en_l), .o_sdata(sdata_l),
    .o_svalid(svalid_l), .in_sready(in_sready), .o_slast(slast_l),
    .o_words(words_l)
  );

  fifo_rd_serializer #(.W(32), .S(8), .LSB_FIRST(1'b0)) dut_m (
    .in_clk(clk), .in_rst_n(rst_n), .in_empty(in_empty),
    .in_data(in_data), .o_r_en(r_en_m), .o_sdata(sdata_m),
    .o_svalid(svalid_m), .in_sready(in_sready), .o_slast(slast_m),
    .o_words(words_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: FIFO pops on r_en and presents data right after the edge
  task automatic cyc();
    logic pop;
    pop = r_en_l;
    @(posedge clk);
    #1;
    if (pop) begin
      if (fq.size() == 0) chk("underread", 32'd1, 32'd0);
      else in_data = fq.pop_front();
    end
    in_empty = (fq.size() == 0);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    in_empty = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_sready = 1'b1;
    fq.delete();
    in_empty  = 1'b1;
    in_data   = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  logic [7:0] bl[4];
  logic [7:0] bm[4];
  int nr;
  int seen;
  logic [7:0] expd;

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    in_sready = 1'b1;
    in_empty = 1'b1;
    in_data = '0;
    #2;
    chk("rst_valid", {31'd0, svalid_l}, 32'd0);
    chk("rst_last",  {31'd0, slast_l}, 32'd0);
    chk("rst_sdata", {24'd0, sdata_l}, 32'd0);
    chk("rst_words", {16'd0, words_l}, 32'd0);
    chk("rst_ren",   {31'd0, r_en_l}, 32'd0);
    do_reset();

    // Single word, both bit orders
    bl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bm = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    push(32'hDDCCBBAA);
    chk("t1_ren", {31'd0, r_en_l}, 32'd1);
    cyc();
    chk("t1_wait_valid", {31'd0, svalid_l}, 32'd0);
    chk("t1_wait_ren", {31'd0, r_en_l}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_valid", {31'd0, svalid_l}, 32'd1);
      chk("t1_lsb", {24'd0, sdata_l}, {24'd0, bl[i]});
      chk("t1_msb", {24'd0, sdata_m}, {24'd0, bm[i]});
      chk("t1_last", {31'd0, slast_l}, (i == 3) ? 32'd1 : 32'd0);
      chk("t1_ren_sh", {31'd0, r_en_l}, 32'd0);
    end
    cyc();
    chk("t1_idle_valid", {31'd0, svalid_l}, 32'd0);
    chk("t1_words", {16'd0, words_l}, 32'd1);
    chk("t1_words_m", {16'd0, words_m}, 32'd1);

    // Two back-to-back words with a single bubble
    do_reset();
    push(32'h03020100);
    push(32'h07060504);
    nr = 0;
    seen = 0;
    expd = 8'h00;
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) cyc();
      if (r_en_l) nr++;
      chk("t3_valid", {31'd0, svalid_l},
          (k == 0 || k == 1 || k == 6 || k == 11) ? 32'd0 : 32'd1);
      if (svalid_l) begin
        chk("t3_data", {24'd0, sdata_l}, {24'd0, expd});
        chk("t3_last", {31'd0, slast_l},
            (expd == 8'h03 || expd == 8'h07) ? 32'd1 : 32'd0);
        expd++;
        seen++;
      end
    end
    chk("t3_beats", seen, 32'd8);
    chk("t3_pops", nr, 32'd2);
    chk("t3_words", {16'd0, words_l}, 32'd2);

    // Back-pressure on beat 1 with more data waiting
    do_reset();
    push(32'hDDCCBBAA);
    cyc();
    cyc();
    chk("t4_b0", {24'd0, sdata_l}, 32'hAA);
    cyc();
    chk("t4_b1", {24'd0, sdata_l}, 32'hBB);
    push(32'h11223344);
    in_sready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_hold_data", {24'd0, sdata_l}, 32'hBB);
      chk("t4_hold_valid", {31'd0, svalid_l}, 32'd1);
      chk("t4_hold_ren", {31'd0, r_en_l}, 32'd0);
      chk("t4_hold_last", {31'd0, slast_l}, 32'd0);
    end
    in_sready = 1'b1;
    #1;
    cyc();
    chk("t4_resume", {24'd0, sdata_l}, 32'hCC);
    cyc();
    chk("t4_final", {24'd0, sdata_l}, 32'hDD);
    chk("t4_final_ren", {31'd0, r_en_l}, 32'd1);
    cyc();
    chk("t4_bubble", {31'd0, svalid_l}, 32'd0);
    cyc();
    chk("t4_next", {24'd0, sdata_l}, 32'h44);
    chk("t4_words", {16'd0, words_l}, 32'd1);

    // Permanently empty FIFO
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t5_ren", {31'd0, r_en_l}, 32'd0);
      chk("t5_valid", {31'd0, svalid_l}, 32'd0);
    end

    // Asynchronous reset during beat 2
    do_reset();
    push(32'hDDCCBBAA);
    cyc();
    cyc();
    cyc();
    cyc();
    chk("t6_b2", {24'd0, sdata_l}, 32'hCC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, svalid_l}, 32'd0);
    chk("t6_last", {31'd0, slast_l}, 32'd0);
    chk("t6_sdata", {24'd0, sdata_l}, 32'd0);
    chk("t6_words", {16'd0, words_l}, 32'd0);
    chk("t6_ren", {31'd0, r_en_l}, 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t6_post_valid", {31'd0, svalid_l}, 32'd0);
      chk("t6_post_ren", {31'd0, r_en_l}, 32'd0);
    end
    chk("t6_post_words", {16'd0, words_l}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
